// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared types and sizing for the mux4 scan controller
package mux_scan_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_t;
  localparam int NCH = 4;
  localparam int IDX_W = 2;
  function automatic int timer_w(input int settle);
    return settle > 0 ? $clog2(settle + 1) : 1;
  endfunction
endpackage

// File: rtl/mux_scan_timer.sv
// mux_scan_timer: per-channel settle counter, expire when count reaches SETTLE
module mux_scan_timer
  import mux_scan_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int TW = timer_w(SETTLE);
  logic [TW-1:0] r_cnt;
  assign expire = r_cnt == TW'(SETTLE);
  // count up while enabled, holding at SETTLE so it never wraps
  always_ff @(posedge clk) begin
    if (!rst_n) r_cnt <= '0;
    else if (clr) r_cnt <= '0;
    else if (en && !expire) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: scans mux4 channels 0..3 into a 4-bit word with valid/ready (macro MUX_SCAN_CONT_EN: continuous mode)
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y,
  output logic       s0,
  output logic       s1,
  output logic       e,
  output logic [3:0] data_out,
  output logic       valid,
  input  logic       ready,
  output logic       busy
);
`ifdef MUX_SCAN_CONT_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif
  scan_state_t      r_state;
  logic [IDX_W-1:0] r_idx;
  logic [NCH-1:0]   r_data;
  logic             r_e;
  logic             r_valid;
  logic             r_busy;
  logic             w_expire;
  logic             w_go;
  assign w_go = start || CONT;
  mux_scan_timer #(.SETTLE(SETTLE)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (r_state != SCAN || w_expire),
    .en     (r_state == SCAN),
    .expire (w_expire)
  );
  assign s0       = r_idx[0];
  assign s1       = r_idx[1];
  assign e        = r_e;
  assign data_out = r_data;
  assign valid    = r_valid;
  assign busy     = r_busy;
  // scan sequencer: select channel, sample y when its settle window ends, hand off word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_data  <= '0;
      r_e     <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_go) begin
          r_state <= SCAN;
          r_idx   <= '0;
          r_e     <= 1'b1;
          r_busy  <= 1'b1;
        end
        SCAN: if (w_expire) begin
          r_data[r_idx] <= y;
          if (r_idx == IDX_W'(NCH - 1)) begin
            r_state <= DONE;
            r_idx   <= '0;
            r_valid <= 1'b1;
            r_e     <= 1'b0;
            r_busy  <= 1'b0;
          end else r_idx <= r_idx + 1'b1;
        end
        DONE: if (ready) begin
          r_valid <= 1'b0;
          r_state <= CONT ? SCAN : IDLE;
          r_e     <= CONT;
          r_busy  <= CONT;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed checks of the scan controller with an inline mux4 model (macro MUX_SCAN_CONT_EN: continuous-mode checks)
module tb_mux_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n, ready, start1, start0, start3;
  logic [3:0] in_v;
  logic y1, s0_1, s1_1, e1, valid1, busy1;
  logic y0, s0_0, s1_0, e0, valid0, busy0;
  logic y3, s0_3, s1_3, e3, valid3, busy3;
  logic [3:0] d1, d0, d3;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  assign y1 = e1 ? in_v[{s1_1, s0_1}] : 1'b0;
  assign y0 = e0 ? in_v[{s1_0, s0_0}] : 1'b0;
  assign y3 = e3 ? in_v[{s1_3, s0_3}] : 1'b0;
  mux_scan_ctrl #(.SETTLE(1)) u1 (.clk(clk), .rst_n(rst_n), .start(start1), .y(y1), .s0(s0_1), .s1(s1_1),
    .e(e1), .data_out(d1), .valid(valid1), .ready(ready), .busy(busy1));
  mux_scan_ctrl #(.SETTLE(0)) u0 (.clk(clk), .rst_n(rst_n), .start(start0), .y(y0), .s0(s0_0), .s1(s1_0),
    .e(e0), .data_out(d0), .valid(valid0), .ready(ready), .busy(busy0));
  mux_scan_ctrl #(.SETTLE(3)) u3 (.clk(clk), .rst_n(rst_n), .start(start3), .y(y3), .s0(s0_3), .s1(s1_3),
    .e(e3), .data_out(d3), .valid(valid3), .ready(ready), .busy(busy3));
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    rst_n = 1'b0; ready = 1'b0; start1 = 1'b0; start0 = 1'b0; start3 = 1'b0; in_v = 4'b0000;
`ifdef MUX_SCAN_CONT_EN
    ready = 1'b1;
    in_v = 4'b0011;
    tick(2);
    chk("cont_rst", {valid1, busy1, e1}, 3'b000);
    rst_n = 1'b1;
    tick();
    chk("cont_autostart", {busy1, e1}, 2'b11);
    for (int t = 1; t <= 26; t++) begin
      tick();
      chk("cont_valid", valid1, (t % 9 == 8) ? 1'b1 : 1'b0);
      if (t % 9 == 8) chk("cont_data", d1, 4'b0011);
    end
`else
    start1 = 1'b1;
    tick(2);
    chk("rst_outs", {s1_1, s0_1, e1, valid1, busy1, d1}, 9'h000);
    rst_n = 1'b1;
    start1 = 1'b0;
    tick();
    chk("rst_idle", {busy1, e1}, 2'b00);
    in_v = 4'b1010;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("scan_begin", {s1_1, s0_1, e1, busy1, valid1}, 5'b00110);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("scan_step", {s1_1, s0_1, e1, busy1, valid1}, {2'(k / 2), 3'b110});
    end
    tick();
    chk("scan_done", {s1_1, s0_1, e1, busy1, valid1, d1}, {5'b00001, 4'b1010});
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("handshake", {valid1, busy1}, 2'b00);
    in_v = 4'b0110;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick(8);
    chk("bp_valid", {valid1, d1}, 5'b10110);
    for (int c = 0; c < 5; c++) begin
      start1 = (c == 2);
      tick();
      chk("bp_hold", {valid1, busy1, e1, d1}, 7'b1000110);
    end
    start1 = 1'b0;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("bp_release", valid1, 1'b0);
    tick();
    chk("bp_noscan", {busy1, e1}, 2'b00);
    in_v = 4'b1111;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick(2);
    chk("mid_busy", busy1, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst", {e1, busy1, valid1, d1}, 7'b0000000);
    begin
      logic seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
        tick();
        seen |= valid1 | busy1;
      end
      chk("mid_quiet", seen, 1'b0);
    end
    in_v = 4'b1111;
    ready = 1'b0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick(3);
    chk("s0_early", valid0, 1'b0);
    tick();
    chk("s0_done", {valid0, d0}, 5'b11111);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("s0_ack", valid0, 1'b0);
    in_v = 4'b1110;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    tick(2);
    in_v[0] = 1'b1;
    tick(2);
    in_v[0] = 1'b0;
    tick(11);
    chk("s3_early", valid3, 1'b0);
    tick();
    chk("s3_done", {valid3, d3}, 5'b11111);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("s3_ack", valid3, 1'b0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
